// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge
// Buffers streams between a BFT leaf_interface and an HLS user kernel. Every
// channel has its own show-ahead FIFO, so stalls on the kernel side and on the
// leaf side are decoupled from each other.
//
// Optional feature: define LEAF_STREAM_BRIDGE_CNT_EN to add the xfer_cnt port
// and the CNT_BITS parameter (one downstream-transfer counter per channel).
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   ap_start                   1 = channels run, 0 = every handshake frozen
//   dout_leaf_interface2user   interface -> bridge data, ch i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_interface2user         interface -> bridge valid per channel
//   ack_user2interface         bridge -> interface ready per channel
//   in_tdata/in_tvalid         bridge -> kernel input streams
//   in_tready                  kernel -> bridge ready
//   out_tdata/out_tvalid       kernel -> bridge output streams
//   out_tready                 bridge -> kernel ready
//   din_leaf_user2interface    bridge -> interface data
//   vld_user2interface         bridge -> interface valid
//   ack_interface2user         interface -> bridge ready
//   idle                       registered: every FIFO empty
//   xfer_cnt                   (feature only) counters, input channels first
//
// Channels are numbered 0..NUM_IN_PORTS-1 for interface->kernel and
// NUM_IN_PORTS.. for kernel->interface; all share one FIFO implementation.
module leaf_stream_bridge #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 1,
  parameter int unsigned DEPTH_LOG2    = 4
`ifdef LEAF_STREAM_BRIDGE_CNT_EN
  ,
  parameter int unsigned CNT_BITS      = 32
`endif
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ap_start,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata,
  output logic [NUM_IN_PORTS-1:0]               in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]               in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]              out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]              out_tready,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic                                  idle
`ifdef LEAF_STREAM_BRIDGE_CNT_EN
  ,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0] xfer_cnt
`endif
);

  localparam int unsigned NCH   = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = DEPTH_LOG2;

  // Unified per-channel views of the upstream and downstream sides
  logic [NCH-1:0]          up_vld;
  logic [NCH-1:0]          up_rdy;
  logic [NCH-1:0]          dn_vld;
  logic [NCH-1:0]          dn_rdy;
  logic [PAYLOAD_BITS-1:0] up_data [NCH];
  logic [PAYLOAD_BITS-1:0] head    [NCH];

  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] empty_nxt;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  // Handshakes are only possible while started and outside reset
  logic run;
  assign run = ap_start & ~reset;

  // Interface -> kernel channel mapping
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_map
    assign up_vld[i]  = vld_interface2user[i];
    assign up_data[i] = dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign dn_rdy[i]  = in_tready[i];

    assign ack_user2interface[i]                    = up_rdy[i];
    assign in_tvalid[i]                             = dn_vld[i];
    assign in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS] = head[i];
  end

  // Kernel -> interface channel mapping
  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out_map
    localparam int unsigned C = NUM_IN_PORTS + j;

    assign up_vld[C]  = out_tvalid[j];
    assign up_data[C] = out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign dn_rdy[C]  = ack_interface2user[j];

    assign out_tready[j]                                           = up_rdy[C];
    assign vld_user2interface[j]                                   = dn_vld[C];
    assign din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS] = head[C];
  end

  // Per-channel show-ahead FIFO
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty
    assign full[c]  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty[c] = (wr_ptr == rd_ptr);

    // Ready/valid depend on registered pointers plus run only
    assign up_rdy[c] = run & ~full[c];
    assign dn_vld[c] = run & ~empty[c];
    assign push[c]   = up_vld[c] & up_rdy[c];
    assign pop[c]    = dn_vld[c] & dn_rdy[c];

    assign head[c] = mem[rd_ptr[AW-1:0]];

    assign empty_nxt[c] = ((wr_ptr + PW'(push[c])) == (rd_ptr + PW'(pop[c])));

    // Pointer update; reset discards contents by clearing both pointers
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[c])  rd_ptr <= rd_ptr + PW'(1);
      end
    end

    // Storage has no reset; push is already blocked during reset
    always_ff @(posedge clk) begin
      if (push[c]) mem[wr_ptr[AW-1:0]] <= up_data[c];
    end
  end

  // Idle drops as soon as a beat is accepted and returns only once every
  // FIFO has been empty both before and after the update
  always_ff @(posedge clk) begin
    if (reset) idle <= 1'b1;
    else       idle <= &(empty & empty_nxt);
  end

`ifdef LEAF_STREAM_BRIDGE_CNT_EN
  // Downstream-side transfer counters, wrapping
  for (genvar c = 0; c < NCH; c++) begin : g_cnt
    logic [CNT_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset)       cnt <= '0;
      else if (pop[c]) cnt <= cnt + CNT_BITS'(1);
    end

    assign xfer_cnt[c*CNT_BITS +: CNT_BITS] = cnt;
  end
`endif

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Testbench for leaf_stream_bridge (default parameters: 2 in, 1 out, depth 16).
// Channels 0..1 are interface->kernel, channel 2 is kernel->interface.
module tb_leaf_stream_bridge;

  localparam int unsigned PB    = 32;
  localparam int unsigned NI    = 2;
  localparam int unsigned NO    = 1;
  localparam int unsigned NCH   = 3;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic reset;
  logic ap_start;

  logic [NI*PB-1:0] dout_leaf_interface2user;
  logic [NI-1:0]    vld_interface2user;
  logic [NI-1:0]    ack_user2interface;
  logic [NI*PB-1:0] in_tdata;
  logic [NI-1:0]    in_tvalid;
  logic [NI-1:0]    in_tready;
  logic [NO*PB-1:0] out_tdata;
  logic [NO-1:0]    out_tvalid;
  logic [NO-1:0]    out_tready;
  logic [NO*PB-1:0] din_leaf_user2interface;
  logic [NO-1:0]    vld_user2interface;
  logic [NO-1:0]    ack_interface2user;
  logic             idle;
`ifdef LEAF_STREAM_BRIDGE_CNT_EN
  logic [NCH*32-1:0] xfer_cnt;
`endif

  // Bench-side channel views: uv/ud/dr driven, ur/dv/dd observed
  logic [NCH-1:0] uv;
  logic [NCH-1:0] dr;
  logic [PB-1:0]  ud [NCH];
  logic [NCH-1:0] ur;
  logic [NCH-1:0] dv;
  logic [PB-1:0]  dd [NCH];

  assign vld_interface2user       = uv[NI-1:0];
  assign out_tvalid               = uv[NCH-1:NI];
  assign in_tready                = dr[NI-1:0];
  assign ack_interface2user       = dr[NCH-1:NI];
  assign dout_leaf_interface2user = {ud[1], ud[0]};
  assign out_tdata                = ud[2];
  assign ur    = {out_tready, ack_user2interface};
  assign dv    = {vld_user2interface, in_tvalid};
  assign dd[0] = in_tdata[31:0];
  assign dd[1] = in_tdata[63:32];
  assign dd[2] = din_leaf_user2interface;

  leaf_stream_bridge dut (
    .clk                      (clk),
    .reset                    (reset),
    .ap_start                 (ap_start),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .in_tdata                 (in_tdata),
    .in_tvalid                (in_tvalid),
    .in_tready                (in_tready),
    .out_tdata                (out_tdata),
    .out_tvalid               (out_tvalid),
    .out_tready               (out_tready),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
    .ack_interface2user       (ack_interface2user),
    .idle                     (idle)
`ifdef LEAF_STREAM_BRIDGE_CNT_EN
    ,
    .xfer_cnt                 (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Transfer logs: beats accepted upstream and beats delivered downstream
  logic [PB-1:0] sent [NCH][$];
  logic [PB-1:0] got  [NCH][$];
  // Stimulus list for the random test
  logic [PB-1:0] exp_q [NCH][$];

  // One clock: record handshakes mid-cycle, return just after the next edge
  task automatic tick();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (uv[c] && ur[c]) sent[c].push_back(ud[c]);
      if (dv[c] && dr[c]) got[c].push_back(dd[c]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int c = 0; c < NCH; c++) begin
      sent[c].delete();
      got[c].delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ap_start = 1'b1; uv = '1; dr = '0;
    for (int c = 0; c < NCH; c++) ud[c] = $urandom;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (ur !== 3'b000 || dv !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: ready=%b valid=%b, required 000/000", k, ur, dv);
      end
    end
    reset = 1'b0; uv = '0;
    #1;
    n_chk++;
    if (idle !== 1'b1 || ur !== 3'b111 || dv !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: idle=%b ready=%b valid=%b, required 1/111/000", idle, ur, dv);
    end
    clear_log();
  endtask

  task automatic test_single_beat();
    clear_log();
    uv = '0; dr = '1;
    ud[0] = 32'hDEAD_BEEF; uv[0] = 1'b1;
    #1;
    n_chk++;
    if (ur[0] !== 1'b1 || dv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n: ack=%b tvalid=%b, required 1/0", ur[0], dv[0]);
    end
    tick();
    uv[0] = 1'b0;
    #1;
    n_chk++;
    if (dv[0] !== 1'b1 || dd[0] !== 32'hDEAD_BEEF || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n1: tvalid=%b data=%h idle=%b, required 1/deadbeef/0", dv[0], dd[0], idle);
    end
    tick();
    n_chk++;
    if (dv[0] !== 1'b0 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n2: tvalid=%b idle=%b, required 0/0", dv[0], idle);
    end
    tick();
    n_chk++;
    if (idle !== 1'b1 || got[0].size() != 1) begin
      n_fail++;
      $display("FAIL single_n3: idle=%b delivered=%0d, required 1/1", idle, got[0].size());
    end else begin
      n_chk++;
      if (got[0][0] !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL single_data: got %h, required deadbeef", got[0][0]);
      end
    end
  endtask

  task automatic test_fill();
    clear_log();
    uv = '0; dr = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ud[0] = PB'(k); uv[0] = 1'b1;
      #1;
      n_chk++;
      if (ur[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ack push%0d: ack=%b, required 1", k, ur[0]);
      end
      tick();
    end
    n_chk++;
    if (ur[0] !== 1'b0 || dv[0] !== 1'b1 || dd[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL fill_full: ack=%b tvalid=%b head=%h, required 0/1/0", ur[0], dv[0], dd[0]);
    end
    ud[0] = 32'd99;
    tick();
    n_chk++;
    if (ur[0] !== 1'b0 || sent[0].size() != DEPTH) begin
      n_fail++;
      $display("FAIL fill_block: ack=%b accepted=%0d, required 0/16", ur[0], sent[0].size());
    end
    uv[0] = 1'b0; dr[0] = 1'b1;
    tick();
    n_chk++;
    if (ur[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_ack_rise: ack=%b, required 1", ur[0]);
    end
    for (int cyc = 0; cyc < 40 && got[0].size() < DEPTH; cyc++) tick();
    dr = '0;
    n_chk++;
    if (got[0].size() != DEPTH) begin
      n_fail++;
      $display("FAIL fill_drain_count: got %0d, required 16", got[0].size());
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        n_chk++;
        if (got[0][k] !== PB'(k)) begin
          n_fail++;
          $display("FAIL fill_order idx%0d: got %h, required %h", k, got[0][k], PB'(k));
        end
      end
    end
  endtask

  task automatic test_wrap_random();
    int cyc;
    int errs;
    clear_log();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      for (int k = 0; k < 100; k++) exp_q[c].push_back($urandom);
    end
    cyc = 0;
    errs = 0;
    while ((got[0].size() < 100 || got[1].size() < 100 || got[2].size() < 100) && cyc < 4000) begin
      for (int c = 0; c < NCH; c++) begin
        if (sent[c].size() < 100) begin
          uv[c] = ($urandom_range(0, 3) != 0);
          ud[c] = exp_q[c][sent[c].size()];
        end else begin
          uv[c] = 1'b0;
          ud[c] = $urandom;
        end
        dr[c] = ($urandom_range(0, 99) < ((cyc < 150) ? 15 : 70));
      end
      tick();
      // Occupancy model: accepted minus delivered
      for (int c = 0; c < NCH; c++) begin
        int occ;
        logic ev, er;
        occ = sent[c].size() - got[c].size();
        ev = (occ > 0);
        er = (occ < DEPTH);
        n_chk++;
        if (dv[c] !== ev || ur[c] !== er || (ev && dd[c] !== exp_q[c][got[c].size()])) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL wrap_cycle ch%0d cyc%0d: valid=%b ready=%b data=%h, required %b/%b/%h",
                     c, cyc, dv[c], ur[c], dd[c], ev, er,
                     ev ? exp_q[c][got[c].size()] : 32'h0);
        end
      end
      cyc++;
    end
    uv = '0; dr = '0;
    for (int c = 0; c < NCH; c++) begin
      int bad;
      bad = 0;
      if (got[c].size() != 100) bad = 1;
      else for (int k = 0; k < 100; k++) if (got[c][k] !== exp_q[c][k]) bad++;
      n_chk++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL wrap_scoreboard ch%0d: delivered=%0d with %0d bad, required 100 exact",
                 c, got[c].size(), bad);
      end
    end
    tick();
    tick();
    n_chk++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_idle: idle=%b, required 1", idle);
    end
  endtask

  task automatic test_ap_start();
    clear_log();
    uv = '0; dr = '0;
    for (int k = 0; k < 3; k++) begin
      ud[0] = 32'hA000_0000 + PB'(k); uv[0] = 1'b1;
      tick();
    end
    ap_start = 1'b0; uv = '1; dr = '1;
    for (int c = 0; c < NCH; c++) ud[c] = $urandom;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if (ur !== 3'b000 || dv !== 3'b000 || idle !== 1'b0) begin
        n_fail++;
        $display("FAIL gap cyc%0d: ready=%b valid=%b idle=%b, required 000/000/0", k, ur, dv, idle);
      end
      tick();
    end
    n_chk++;
    if (sent[0].size() != 3 || sent[1].size() != 0 || sent[2].size() != 0 ||
        got[0].size() != 0 || got[1].size() != 0 || got[2].size() != 0) begin
      n_fail++;
      $display("FAIL gap_handshakes: accepted=%0d/%0d/%0d delivered=%0d/%0d/%0d, required 3/0/0 0/0/0",
               sent[0].size(), sent[1].size(), sent[2].size(),
               got[0].size(), got[1].size(), got[2].size());
    end
    ap_start = 1'b1; uv = '0;
    for (int cyc = 0; cyc < 20 && got[0].size() < 3; cyc++) tick();
    n_chk++;
    if (got[0].size() != 3) begin
      n_fail++;
      $display("FAIL resume_count: got %0d, required 3", got[0].size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (got[0][k] !== 32'hA000_0000 + PB'(k)) begin
          n_fail++;
          $display("FAIL resume_data idx%0d: got %h, required %h", k, got[0][k], 32'hA000_0000 + PB'(k));
        end
      end
    end
    dr = '0;
  endtask

  task automatic test_mid_reset();
    clear_log();
    uv = '0; dr = '0;
    for (int k = 0; k < 7; k++) begin
      ud[0] = 32'hC000_0000 + PB'(k); uv[0] = 1'b1;
      ud[2] = 32'hE000_0000 + PB'(k); uv[2] = 1'b1;
      tick();
    end
    n_chk++;
    if (sent[0].size() != 7 || dv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_fill: accepted=%0d tvalid=%b, required 7/1", sent[0].size(), dv[0]);
    end
    reset = 1'b1; uv = '1; dr = '1;
    #1;
    n_chk++;
    if (ur !== 3'b000 || dv !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_cycle: ready=%b valid=%b, required 000/000", ur, dv);
    end
    tick();
    reset = 1'b0; uv = '0;
    clear_log();
    #1;
    n_chk++;
    if (idle !== 1'b1 || dv !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_after: idle=%b valid=%b, required 1/000", idle, dv);
    end
`ifdef LEAF_STREAM_BRIDGE_CNT_EN
    n_chk++;
    if (xfer_cnt !== '0) begin
      n_fail++;
      $display("FAIL cnt_cleared: xfer_cnt=%h, required 0", xfer_cnt);
    end
`endif
    for (int k = 0; k < 10; k++) tick();
    n_chk++;
    if (got[0].size() != 0 || got[1].size() != 0 || got[2].size() != 0) begin
      n_fail++;
      $display("FAIL midrst_stale: delivered=%0d/%0d/%0d, required 0/0/0",
               got[0].size(), got[1].size(), got[2].size());
    end
    for (int k = 0; k < 5; k++) begin
      ud[0] = 32'hB000_0000 + PB'(k); uv[0] = 1'b1;
      tick();
    end
    uv = '0;
    for (int k = 0; k < 3; k++) tick();
    n_chk++;
    if (got[0].size() != 5) begin
      n_fail++;
      $display("FAIL midrst_fresh_count: got %0d, required 5", got[0].size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (got[0][k] !== 32'hB000_0000 + PB'(k)) begin
          n_fail++;
          $display("FAIL midrst_fresh idx%0d: got %h, required %h", k, got[0][k], 32'hB000_0000 + PB'(k));
        end
      end
    end
`ifdef LEAF_STREAM_BRIDGE_CNT_EN
    n_chk++;
    if (xfer_cnt !== {32'd0, 32'd0, 32'd5}) begin
      n_fail++;
      $display("FAIL cnt_five: xfer_cnt=%h, required 0/0/5", xfer_cnt);
    end
`endif
    dr = '0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    ap_start = 1'b1;
    uv = '0;
    dr = '0;
    for (int c = 0; c < NCH; c++) ud[c] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_beat();
    test_fill();
    test_wrap_random();
    test_ap_start();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
